id_ex_skid_reg: RTL and testbench

ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

---
 rtl/id_ex_skid_reg.sv | 95 +++++++++
 tb/tb_id_ex_skid_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a one-entry skid buffer, so in_ready depends
// only on registered state, plus a saturating count of bubble cycles.
module id_ex_skid_reg #(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_DATA = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_wreg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wreg,
  output logic [1:0]        count,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              main_wreg;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_wreg;
  logic              accept;
  logic              pop;

  assign in_ready = !skid_valid;
  assign accept   = in_valid & in_ready;
  assign pop      = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : NOP_DATA;
  assign out_wreg  = main_valid ? main_wreg : 1'b0;
  assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

  // The skid entry is only ever occupied while main is, so main empty
  // implies skid empty and the cases below are exhaustive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= NOP_DATA;
      main_wreg  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= NOP_DATA;
      skid_wreg  <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_data  <= NOP_DATA;
      main_wreg  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= NOP_DATA;
      skid_wreg  <= 1'b0;
    end else if (!main_valid) begin
      if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
        main_wreg  <= in_wreg;
      end
    end else if (!pop) begin
      if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        skid_wreg  <= in_wreg;
      end
    end else if (skid_valid) begin
      main_data  <= skid_data;
      main_wreg  <= skid_wreg;
      skid_valid <= 1'b0;
      skid_data  <= NOP_DATA;
      skid_wreg  <= 1'b0;
    end else if (accept) begin
      main_data  <= in_data;
      main_wreg  <= in_wreg;
    end else begin
      main_valid <= 1'b0;
      main_data  <= NOP_DATA;
      main_wreg  <= 1'b0;
    end
  end

  // Saturates rather than wraps so a long idle stretch never reads as short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!main_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Self-checking bench for id_ex_skid_reg: hand-computed vector table plus a
// queue scoreboard that models the in-flight payloads and bubble counter.
module tb_id_ex_skid_reg;

  localparam int          DATA_W = 32;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] NOP    = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_wreg;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_wreg;
  logic [1:0]        count;
  logic [CNT_W-1:0]  bubble_cnt;

  id_ex_skid_reg #(.DATA_W(DATA_W), .NOP_DATA(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_wreg(in_wreg),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_wreg(out_wreg),
    .count(count), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              wreg;
  } entry_t;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        iw;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic        ew;
    logic [1:0]  ec;
    logic        er;
  } vec_t;

  entry_t           sb_q[$];
  logic [CNT_W-1:0] exp_bub;
  vec_t             vecs[$];
  int               checks = 0;
  int               passed = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] id, input logic iw,
                               input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    in_wreg   = iw;
    out_ready = ordy;
    flush     = fl;
    #3;
  endtask

  // Compare the current outputs with what the scoreboard says is held.
  task automatic scoreboardCheck();
    int n;
    n = sb_q.size();
    checkOutput("sb_count", 64'(count), 64'(n));
    checkOutput("sb_in_ready", 64'(in_ready), 64'(n < 2));
    checkOutput("sb_out_valid", 64'(out_valid), 64'(n > 0));
    checkOutput("sb_out_data", 64'(out_data), 64'((n > 0) ? sb_q[0].data : NOP));
    checkOutput("sb_out_wreg", 64'(out_wreg), 64'((n > 0) ? sb_q[0].wreg : 1'b0));
    checkOutput("sb_bubble_cnt", 64'(bubble_cnt), 64'(exp_bub));
  endtask

  // Update the model with the inputs currently driven, then cross the edge.
  task automatic advance();
    logic pop_e, acc_e;
    entry_t e;
    pop_e = (sb_q.size() > 0) && out_ready;
    acc_e = in_valid && (sb_q.size() < 2);
    if ((sb_q.size() == 0) && (exp_bub != {CNT_W{1'b1}})) exp_bub = exp_bub + 1'b1;
    if (pop_e) void'(sb_q.pop_front());
    if (flush) sb_q.delete();
    else if (acc_e) begin
      e.data = in_data;
      e.wreg = in_wreg;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic iv, input logic [31:0] id, input logic iw, input logic ordy,
                        input logic fl, input logic ev, input logic [31:0] ed, input logic ew,
                        input logic [1:0] ec, input logic er);
    vec_t v;
    v.iv = iv; v.id = id; v.iw = iw; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ed = ed; v.ew = ew; v.ec = ec; v.er = er;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_wreg = 1'b0; out_ready = 1'b0; flush = 1'b0;
    exp_bub = '0;

    // Streaming, out_ready high
    addVec(1'b1, 32'h1,  1'b1, 1'b1, 1'b0,  1'b0, NOP,   1'b0, 2'd0, 1'b1);
    addVec(1'b1, 32'h2,  1'b0, 1'b1, 1'b0,  1'b1, 32'h1, 1'b1, 2'd1, 1'b1);
    addVec(1'b1, 32'h3,  1'b1, 1'b1, 1'b0,  1'b1, 32'h2, 1'b0, 2'd1, 1'b1);
    addVec(1'b0, 32'h0,  1'b0, 1'b1, 1'b0,  1'b1, 32'h3, 1'b1, 2'd1, 1'b1);
    addVec(1'b0, 32'h0,  1'b0, 1'b1, 1'b0,  1'b0, NOP,   1'b0, 2'd0, 1'b1);
    // Backpressure: A, B held, C refused until space frees
    addVec(1'b1, 32'hA,  1'b0, 1'b0, 1'b0,  1'b0, NOP,   1'b0, 2'd0, 1'b1);
    addVec(1'b1, 32'hB,  1'b1, 1'b0, 1'b0,  1'b1, 32'hA, 1'b0, 2'd1, 1'b1);
    addVec(1'b1, 32'hC,  1'b1, 1'b0, 1'b0,  1'b1, 32'hA, 1'b0, 2'd2, 1'b0);
    addVec(1'b1, 32'hC,  1'b1, 1'b0, 1'b0,  1'b1, 32'hA, 1'b0, 2'd2, 1'b0);
    addVec(1'b0, 32'h0,  1'b0, 1'b1, 1'b0,  1'b1, 32'hA, 1'b0, 2'd2, 1'b0);
    addVec(1'b1, 32'hC,  1'b1, 1'b1, 1'b0,  1'b1, 32'hB, 1'b1, 2'd1, 1'b1);
    addVec(1'b0, 32'h0,  1'b0, 1'b1, 1'b0,  1'b1, 32'hC, 1'b1, 2'd1, 1'b1);
    addVec(1'b0, 32'h0,  1'b0, 1'b0, 1'b0,  1'b0, NOP,   1'b0, 2'd0, 1'b1);
    // Flush with two held entries and an incoming 0xF
    addVec(1'b1, 32'hD,  1'b1, 1'b0, 1'b0,  1'b0, NOP,   1'b0, 2'd0, 1'b1);
    addVec(1'b1, 32'hE,  1'b0, 1'b0, 1'b0,  1'b1, 32'hD, 1'b1, 2'd1, 1'b1);
    addVec(1'b0, 32'h0,  1'b0, 1'b0, 1'b0,  1'b1, 32'hD, 1'b1, 2'd2, 1'b0);
    addVec(1'b1, 32'hF,  1'b1, 1'b0, 1'b1,  1'b1, 32'hD, 1'b1, 2'd2, 1'b0);
    addVec(1'b0, 32'h0,  1'b0, 1'b1, 1'b0,  1'b0, NOP,   1'b0, 2'd0, 1'b1);
    // Flush with a same-cycle pop and a discarded accept
    addVec(1'b1, 32'h22, 1'b1, 1'b0, 1'b0,  1'b0, NOP,   1'b0, 2'd0, 1'b1);
    addVec(1'b1, 32'h33, 1'b0, 1'b1, 1'b1,  1'b1, 32'h22,1'b1, 2'd1, 1'b1);
    addVec(1'b0, 32'h0,  1'b0, 1'b1, 1'b0,  1'b0, NOP,   1'b0, 2'd0, 1'b1);
    // Flush while in_ready is high discards the incoming payload
    addVec(1'b1, 32'h44, 1'b1, 1'b0, 1'b0,  1'b0, NOP,   1'b0, 2'd0, 1'b1);
    addVec(1'b1, 32'h55, 1'b1, 1'b0, 1'b1,  1'b1, 32'h44,1'b1, 2'd1, 1'b1);
    addVec(1'b0, 32'h0,  1'b0, 1'b1, 1'b0,  1'b0, NOP,   1'b0, 2'd0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_data", 64'(out_data), 64'(NOP));
    checkOutput("reset_out_wreg", 64'(out_wreg), 64'd0);
    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_bubble_cnt", 64'(bubble_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle 20 cycles: bubble counter must climb and stick at 0xF
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      scoreboardCheck();
      advance();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("bubble_saturated", 64'(bubble_cnt), 64'hF);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].iw, vecs[i].ordy, vecs[i].fl);
      checkOutput($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      checkOutput($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].ed));
      checkOutput($sformatf("vec%0d_out_wreg", i), 64'(out_wreg), 64'(vecs[i].ew));
      checkOutput($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].ec));
      checkOutput($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].er));
      scoreboardCheck();
      advance();
    end

    // Async reset between edges with two entries held
    applyStimulus(1'b1, 32'h66, 1'b1, 1'b0, 1'b0);
    scoreboardCheck();
    advance();
    applyStimulus(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    scoreboardCheck();
    advance();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_count", 64'(count), 64'd2);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_count", 64'(count), 64'd0);
    checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("async_rst_out_data", 64'(out_data), 64'(NOP));
    checkOutput("async_rst_out_wreg", 64'(out_wreg), 64'd0);
    checkOutput("async_rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    exp_bub = '0;

    // Sustained throughput after reset: one payload per cycle
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'(i), 1'b1, 1'b0);
      scoreboardCheck();
      advance();
    end

    // Random traffic with occasional flushes, then drain
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 11) == 0));
      scoreboardCheck();
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      scoreboardCheck();
      advance();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
